// File: rtl/decode_stage_pkg.sv
// Shared RV32I decode definitions: opcode constants, ALU op codes,
// operand-select codes, immediate formats and the decoded payload record.
package decode_stage_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_OP_IMM = 7'h13;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_JAL    = 7'h6F;

  // ALU op codes match funct3 so OP/OP-IMM can pass funct3 straight through
  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_SLL  = 3'd1;
  localparam logic [2:0] ALU_SLT  = 3'd2;
  localparam logic [2:0] ALU_SLTU = 3'd3;
  localparam logic [2:0] ALU_XOR  = 3'd4;
  localparam logic [2:0] ALU_SRL  = 3'd5;
  localparam logic [2:0] ALU_OR   = 3'd6;
  localparam logic [2:0] ALU_AND  = 3'd7;

  localparam logic [1:0] OP1_RS1  = 2'd0;
  localparam logic [1:0] OP1_PC   = 2'd1;
  localparam logic [1:0] OP1_ZERO = 2'd2;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_fmt_e;

  // All-zero value of this record is the NOP decode
  typedef struct packed {
    logic [31:0] pc;
    logic [2:0]  alu_op;
    logic [6:0]  funct7;
    logic [4:0]  shamt;
    logic        is_r_type;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [1:0]  op1_sel;
    logic        op2_imm;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        branch;
    logic        jump;
    logic        illegal;
  } dec_t;

endpackage

// File: rtl/decode_stage_imm_gen.sv
// Combinational RV32I immediate extraction for the I/S/B/U/J formats.
// Opcode bits are not needed, so only inst[31:7] is taken.
module decode_stage_imm_gen
  import decode_stage_pkg::*;
(
  input  logic [31:7] inst,
  input  imm_fmt_e    fmt,
  output logic [31:0] imm
);

  // Select and sign-extend the immediate for the requested format
  always_comb begin
    imm = '0;
    case (fmt)
      IMM_I:   imm = {{20{inst[31]}}, inst[31:20]};
      IMM_S:   imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      IMM_B:   imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      IMM_U:   imm = {inst[31:12], 12'b0};
      IMM_J:   imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: combinational decode feeding a two-entry skid buffer.
// Optional macro DECODE_ILLEGAL_CHECK_EN enables illegal-encoding detection;
// without it `illegal` is always 0 and unknown opcodes simply decode as NOP.
module decode_stage
  import decode_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_inst,
  input  logic [31:0] in_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [2:0]  alu_op,
  output logic [6:0]  funct7,
  output logic [4:0]  shamt,
  output logic        is_r_type,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic [31:0] imm,
  output logic [1:0]  op1_sel,
  output logic        op2_imm,
  output logic        reg_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        branch,
  output logic        jump,
  output logic        illegal
);

  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [6:0]  f7;
  imm_fmt_e    fmt_p0;
  logic [31:0] imm_p0;
  logic        bad_p0;
  dec_t        dec_p0;

  dec_t        main_p1;
  dec_t        skid_p1;
  logic        vld_p1;
  logic        skid_vld_p1;

  assign opcode = in_inst[6:0];
  assign f3     = in_inst[14:12];
  assign f7     = in_inst[31:25];

  // ---- stage p0: combinational decode ----

  // Immediate format chosen by opcode alone
  always_comb begin
    fmt_p0 = IMM_NONE;
    case (opcode)
      OPC_OP_IMM, OPC_LOAD, OPC_JALR: fmt_p0 = IMM_I;
      OPC_STORE:                      fmt_p0 = IMM_S;
      OPC_BRANCH:                     fmt_p0 = IMM_B;
      OPC_LUI, OPC_AUIPC:             fmt_p0 = IMM_U;
      OPC_JAL:                        fmt_p0 = IMM_J;
      default:                        fmt_p0 = IMM_NONE;
    endcase
  end

  decode_stage_imm_gen imm_gen (
    .inst (in_inst[31:7]),
    .fmt  (fmt_p0),
    .imm  (imm_p0)
  );

`ifdef DECODE_ILLEGAL_CHECK_EN
  // Flag unknown opcodes and funct7 values the ALU cannot honour
  always_comb begin
    bad_p0 = 1'b0;
    case (opcode)
      OPC_OP:
        bad_p0 = !((f7 == 7'h00) || ((f7 == 7'h20) && ((f3 == 3'd0) || (f3 == 3'd5))));
      OPC_OP_IMM:
        if (f3 == 3'd1)      bad_p0 = (f7 != 7'h00);
        else if (f3 == 3'd5) bad_p0 = !((f7 == 7'h00) || (f7 == 7'h20));
        else                 bad_p0 = 1'b0;
      OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC:
        bad_p0 = 1'b0;
      default:
        bad_p0 = 1'b1;
    endcase
  end
`else
  assign bad_p0 = 1'b0;
`endif

  // Crack the instruction into ALU control, register indices and enables
  always_comb begin
    dec_p0    = '0;
    dec_p0.pc = in_pc;
    case (opcode)
      OPC_OP: begin
        dec_p0.alu_op    = f3;
        dec_p0.funct7    = f7;
        dec_p0.is_r_type = 1'b1;
        dec_p0.rs1       = in_inst[19:15];
        dec_p0.rs2       = in_inst[24:20];
        dec_p0.rd        = in_inst[11:7];
        dec_p0.reg_write = 1'b1;
      end
      OPC_OP_IMM: begin
        dec_p0.alu_op    = f3;
        // only the shifts carry funct7 (bit 5 selects SRAI)
        dec_p0.funct7    = ((f3 == 3'd1) || (f3 == 3'd5)) ? f7 : 7'h00;
        dec_p0.shamt     = in_inst[24:20];
        dec_p0.rs1       = in_inst[19:15];
        dec_p0.rd        = in_inst[11:7];
        dec_p0.imm       = imm_p0;
        dec_p0.op2_imm   = 1'b1;
        dec_p0.reg_write = 1'b1;
      end
      OPC_LOAD: begin
        dec_p0.rs1       = in_inst[19:15];
        dec_p0.rd        = in_inst[11:7];
        dec_p0.imm       = imm_p0;
        dec_p0.op2_imm   = 1'b1;
        dec_p0.reg_write = 1'b1;
        dec_p0.mem_read  = 1'b1;
      end
      OPC_STORE: begin
        dec_p0.rs1       = in_inst[19:15];
        dec_p0.rs2       = in_inst[24:20];
        dec_p0.imm       = imm_p0;
        dec_p0.op2_imm   = 1'b1;
        dec_p0.mem_write = 1'b1;
      end
      OPC_BRANCH: begin
        dec_p0.rs1       = in_inst[19:15];
        dec_p0.rs2       = in_inst[24:20];
        dec_p0.imm       = imm_p0;
        dec_p0.op1_sel   = OP1_PC;
        dec_p0.op2_imm   = 1'b1;
        dec_p0.branch    = 1'b1;
      end
      OPC_JAL: begin
        dec_p0.rd        = in_inst[11:7];
        dec_p0.imm       = imm_p0;
        dec_p0.op1_sel   = OP1_PC;
        dec_p0.op2_imm   = 1'b1;
        dec_p0.reg_write = 1'b1;
        dec_p0.jump      = 1'b1;
      end
      OPC_JALR: begin
        dec_p0.rs1       = in_inst[19:15];
        dec_p0.rd        = in_inst[11:7];
        dec_p0.imm       = imm_p0;
        dec_p0.op2_imm   = 1'b1;
        dec_p0.reg_write = 1'b1;
        dec_p0.jump      = 1'b1;
      end
      OPC_LUI: begin
        dec_p0.rd        = in_inst[11:7];
        dec_p0.imm       = imm_p0;
        dec_p0.op1_sel   = OP1_ZERO;
        dec_p0.op2_imm   = 1'b1;
        dec_p0.reg_write = 1'b1;
      end
      OPC_AUIPC: begin
        dec_p0.rd        = in_inst[11:7];
        dec_p0.imm       = imm_p0;
        dec_p0.op1_sel   = OP1_PC;
        dec_p0.op2_imm   = 1'b1;
        dec_p0.reg_write = 1'b1;
      end
      default: dec_p0.alu_op = ALU_ADD;
    endcase
    if (bad_p0) begin
      dec_p0         = '0;
      dec_p0.pc      = in_pc;
      dec_p0.illegal = 1'b1;
    end
  end

  // ---- stage p1: two-entry skid buffer ----

  // Main entry drives the outputs; skid entry catches one beat of backpressure
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1      <= 1'b0;
      skid_vld_p1 <= 1'b0;
      main_p1     <= '0;
      skid_p1     <= '0;
    end else if (flush) begin
      vld_p1      <= 1'b0;
      skid_vld_p1 <= 1'b0;
    end else begin
      case ({vld_p1, skid_vld_p1})
        2'b00: begin
          if (in_valid) begin
            main_p1 <= dec_p0;
            vld_p1  <= 1'b1;
          end
        end
        2'b10: begin
          if (out_ready) begin
            if (in_valid) main_p1 <= dec_p0;
            else          vld_p1  <= 1'b0;
          end else if (in_valid) begin
            skid_p1     <= dec_p0;
            skid_vld_p1 <= 1'b1;
          end
        end
        2'b11: begin
          if (out_ready) begin
            main_p1     <= skid_p1;
            skid_vld_p1 <= 1'b0;
          end
        end
        default: begin
          main_p1     <= skid_p1;
          vld_p1      <= 1'b1;
          skid_vld_p1 <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = ~skid_vld_p1;
  assign out_valid = vld_p1;
  assign out_pc    = main_p1.pc;
  assign alu_op    = main_p1.alu_op;
  assign funct7    = main_p1.funct7;
  assign shamt     = main_p1.shamt;
  assign is_r_type = main_p1.is_r_type;
  assign rs1       = main_p1.rs1;
  assign rs2       = main_p1.rs2;
  assign rd        = main_p1.rd;
  assign imm       = main_p1.imm;
  assign op1_sel   = main_p1.op1_sel;
  assign op2_imm   = main_p1.op2_imm;
  assign reg_write = main_p1.reg_write;
  assign mem_read  = main_p1.mem_read;
  assign mem_write = main_p1.mem_write;
  assign branch    = main_p1.branch;
  assign jump      = main_p1.jump;
  assign illegal   = main_p1.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: decode vectors, backpressure, flush, reset.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_inst, in_pc, out_pc, imm;
  logic [2:0]  alu_op;
  logic [6:0]  funct7;
  logic [4:0]  shamt, rs1, rs2, rd;
  logic [1:0]  op1_sel;
  logic        is_r_type, op2_imm, reg_write, mem_read, mem_write, branch, jump, illegal;
  logic        exp_ill;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  decode_stage dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .alu_op(alu_op), .funct7(funct7), .shamt(shamt), .is_r_type(is_r_type),
    .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm),
    .op1_sel(op1_sel), .op2_imm(op2_imm), .reg_write(reg_write),
    .mem_read(mem_read), .mem_write(mem_write), .branch(branch), .jump(jump),
    .illegal(illegal)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
`ifdef DECODE_ILLEGAL_CHECK_EN
    exp_ill = 1'b1;
`else
    exp_ill = 1'b0;
`endif
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_inst = '0; in_pc = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready",  in_ready,  1);
    chk("rst_out_pc",    out_pc,    0);
    chk("rst_alu_op",    alu_op,    0);
    chk("rst_imm",       imm,       0);
    chk("rst_reg_write", reg_write, 0);
    chk("rst_illegal",   illegal,   0);

    // streaming decode, one per cycle
    out_ready = 1'b1; in_valid = 1'b1;
    in_inst = 32'h002081B3; in_pc = 32'h100;   // ADD x3,x1,x2
    @(negedge clk);
    chk("add_valid",  out_valid, 1);
    chk("add_pc",     out_pc,    32'h100);
    chk("add_alu",    alu_op,    0);
    chk("add_f7",     funct7,    0);
    chk("add_rtype",  is_r_type, 1);
    chk("add_rs1",    rs1,       1);
    chk("add_rs2",    rs2,       2);
    chk("add_rd",     rd,        3);
    chk("add_wr",     reg_write, 1);
    in_inst = 32'h402081B3; in_pc = 32'h104;   // SUB x3,x1,x2
    @(negedge clk);
    chk("sub_pc",     out_pc,    32'h104);
    chk("sub_f7",     funct7,    7'h20);
    in_inst = 32'h40435293; in_pc = 32'h108;   // SRAI x5,x6,4
    @(negedge clk);
    chk("srai_alu",   alu_op,    5);
    chk("srai_f7",    funct7,    7'h20);
    chk("srai_shamt", shamt,     4);
    chk("srai_rtype", is_r_type, 0);
    chk("srai_op2",   op2_imm,   1);
    chk("srai_rd",    rd,        5);
    chk("srai_rs1",   rs1,       6);
    in_inst = 32'hFE20AE23; in_pc = 32'h10C;   // SW x2,-4(x1)
    @(negedge clk);
    chk("sw_imm",     imm,       32'hFFFFFFFC);
    chk("sw_mw",      mem_write, 1);
    chk("sw_wr",      reg_write, 0);
    chk("sw_alu",     alu_op,    0);
    in_inst = 32'h123453B7; in_pc = 32'h110;   // LUI x7,0x12345
    @(negedge clk);
    chk("lui_imm",    imm,       32'h12345000);
    chk("lui_op1",    op1_sel,   2);
    chk("lui_rd",     rd,        7);
    in_inst = 32'h008000EF; in_pc = 32'h114;   // JAL x1,8
    @(negedge clk);
    chk("jal_imm",    imm,       8);
    chk("jal_op1",    op1_sel,   1);
    chk("jal_jump",   jump,      1);
    chk("jal_wr",     reg_write, 1);
    in_inst = 32'h0000007F; in_pc = 32'h118;   // unknown opcode
    @(negedge clk);
    chk("unk_pc",     out_pc,    32'h118);
    chk("unk_ill",    illegal,   exp_ill);
    chk("unk_wr",     reg_write, 0);
    chk("unk_mr",     mem_read,  0);
    chk("unk_mw",     mem_write, 0);
    chk("unk_br",     branch,    0);
    chk("unk_jmp",    jump,      0);
    chk("unk_imm",    imm,       0);
    chk("unk_alu",    alu_op,    0);
    in_valid = 1'b0;
    @(negedge clk);
    chk("idle_valid", out_valid, 0);

    // backpressure: ADDI x1,x0,k stream with out_ready low
    out_ready = 1'b0; in_valid = 1'b1;
    in_inst = 32'h00100093; in_pc = 32'h200;
    @(negedge clk);
    chk("bp1_valid",  out_valid, 1);
    chk("bp1_rdy",    in_ready,  1);
    in_inst = 32'h00200093; in_pc = 32'h204;
    @(negedge clk);
    chk("bp2_rdy",    in_ready,  0);
    chk("bp2_pc",     out_pc,    32'h200);
    in_inst = 32'h00300093; in_pc = 32'h208;
    @(negedge clk);
    chk("bp3_rdy",    in_ready,  0);
    chk("bp3_pc",     out_pc,    32'h200);
    chk("bp3_imm",    imm,       1);
    out_ready = 1'b1;
    @(negedge clk);
    chk("dr1_valid",  out_valid, 1);
    chk("dr1_pc",     out_pc,    32'h204);
    chk("dr1_imm",    imm,       2);
    chk("dr1_rdy",    in_ready,  1);
    @(negedge clk);
    chk("dr2_valid",  out_valid, 1);
    chk("dr2_pc",     out_pc,    32'h208);
    chk("dr2_imm",    imm,       3);
    in_valid = 1'b0;
    @(negedge clk);
    chk("dr3_valid",  out_valid, 0);

    // flush with both entries full and an input offered
    out_ready = 1'b0; in_valid = 1'b1;
    in_inst = 32'h00A00093; in_pc = 32'h300;
    @(negedge clk);
    in_inst = 32'h00B00093; in_pc = 32'h304;
    @(negedge clk);
    chk("fl_full",    in_ready,  0);
    in_inst = 32'h00C00093; in_pc = 32'h308; flush = 1'b1;
    @(negedge clk);
    chk("fl_valid",   out_valid, 0);
    chk("fl_rdy",     in_ready,  1);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("fl_post1",   out_valid, 0);
    @(negedge clk);
    chk("fl_post2",   out_valid, 0);

    // flush on an empty buffer drops an input even with in_ready high
    in_valid = 1'b1; in_inst = 32'h00D00093; in_pc = 32'h30C; flush = 1'b1;
    @(negedge clk);
    chk("fle_valid",  out_valid, 0);
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("fle_post",   out_valid, 0);

    // reset mid-stream clears control and payload
    out_ready = 1'b0; in_valid = 1'b1; in_inst = 32'h123453B7; in_pc = 32'h400;
    @(negedge clk);
    chk("mr_valid",   out_valid, 1);
    in_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    chk("mr_out_v",   out_valid, 0);
    chk("mr_rdy",     in_ready,  1);
    chk("mr_pc",      out_pc,    0);
    chk("mr_imm",     imm,       0);
    chk("mr_op1",     op1_sel,   0);
    chk("mr_wr",      reg_write, 0);
    rst = 1'b0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
